// File: rtl/noc_inbuf_fifo.sv
// noc_inbuf_fifo: router input-port flit buffer.
// Circular FIFO with valid/ready on the link side (in_*) and the switch side (out_*).
// Show-ahead head flit, gated to zero while empty. Occupancy and status outputs.
// Sticky overflow flag set by writes attempted while full.
// Optional statistics outputs (drop_cnt, hi_water) are built only when the
// macro NOC_INBUF_STATS_EN is defined.
module noc_inbuf_fifo #(
  parameter int FLIT_W    = 20,
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 40,
  parameter int AFULL_LVL = 36,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [FLIT_W-1:0]       datain,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FLIT_W-1:0]       dataout,
  output logic [FLIT_W-TAG_W-1:0] payload,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    overflow,
`ifdef NOC_INBUF_STATS_EN
  output logic [15:0]             drop_cnt,
  output logic [CW-1:0]           hi_water,
`endif
  input  logic                    clr_overflow
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  // Flit storage; never reset, the empty gate on dataout hides stale contents.
  logic [FLIT_W-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          overflow_set;

  // Status flags are pure decodes of the occupancy counter.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_CNT);
  assign in_ready    = !full;
  assign out_valid   = !empty;

  // Handshakes: a full buffer refuses the write, which is what flags overflow.
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign overflow_set = in_valid && full;

  // Show-ahead head: read straight from the array at rd_ptr, zero while empty.
  assign dataout = empty ? '0 : mem[rd_ptr];
  assign payload = dataout[FLIT_W-1:TAG_W];

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (push) begin
      wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
    end
  end

  // Occupancy: +1 on push only, -1 on pop only, hold on both or neither.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Write port of the flit array; only accepted flits touch memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= datain;
    end
  end

  // Pointers and occupancy, discarded by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Sticky overflow; a new drop in the same cycle as the clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (overflow_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef NOC_INBUF_STATS_EN
  // Dropped-write counter, saturating; cleared with the overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (overflow_set) begin
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (clr_overflow) begin
      drop_cnt <= '0;
    end
  end

  // High-water mark of occupancy since reset, tracking the next count value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_water <= '0;
    end else if (count_next > hi_water) begin
      hi_water <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_noc_inbuf_fifo.sv
// tb_noc_inbuf_fifo: self-checking bench for noc_inbuf_fifo.
// A short vector table covers single-flit and simultaneous push/pop cases;
// hand-written sequences cover fill/overflow/drain, wraparound and async reset.
// A queue scoreboard predicts the flit order and status every cycle.
module tb_noc_inbuf_fifo;

  localparam int FLIT_W    = 20;
  localparam int TAG_W     = 4;
  localparam int DEPTH     = 40;
  localparam int AFULL_LVL = 36;
  localparam int CW        = $clog2(DEPTH + 1);

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic [FLIT_W-1:0]       datain;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [FLIT_W-1:0]       dataout;
  logic [FLIT_W-TAG_W-1:0] payload;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    overflow;
  logic                    clr_overflow;
`ifdef NOC_INBUF_STATS_EN
  logic [15:0]             drop_cnt;
  logic [CW-1:0]           hi_water;
`endif

  noc_inbuf_fifo #(
    .FLIT_W   (FLIT_W),
    .TAG_W    (TAG_W),
    .DEPTH    (DEPTH),
    .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .datain      (datain),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dataout     (dataout),
    .payload     (payload),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
`ifdef NOC_INBUF_STATS_EN
    .drop_cnt    (drop_cnt),
    .hi_water    (hi_water),
`endif
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int miss  = 0;

  // Scoreboard state
  logic [FLIT_W-1:0] sb_q[$];
  int m_ovf  = 0;
  int m_drop = 0;
  int m_hw   = 0;

  typedef struct {
    logic              iv;
    logic [FLIT_W-1:0] d;
    logic              ordy;
    logic              clr;
    int                exp_count;
    logic              exp_ovf;
    logic [FLIT_W-1:0] exp_dout;
    logic [15:0]       exp_payload;
  } vec_t;

  vec_t vtab [0:5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the scoreboard prediction.
  task automatic check_state(input string tag);
    logic [FLIT_W-1:0] exp_d;
    exp_d = (sb_q.size() != 0) ? sb_q[0] : '0;
    chk({tag, " count"},       32'(count),       32'(sb_q.size()));
    chk({tag, " full"},        32'(full),        32'(sb_q.size() == DEPTH));
    chk({tag, " empty"},       32'(empty),       32'(sb_q.size() == 0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(sb_q.size() >= AFULL_LVL));
    chk({tag, " in_ready"},    32'(in_ready),    32'(sb_q.size() != DEPTH));
    chk({tag, " out_valid"},   32'(out_valid),   32'(sb_q.size() != 0));
    chk({tag, " overflow"},    32'(overflow),    32'(m_ovf));
    chk({tag, " dataout"},     32'(dataout),     32'(exp_d));
    chk({tag, " payload"},     32'(payload),     32'(exp_d[FLIT_W-1:TAG_W]));
`ifdef NOC_INBUF_STATS_EN
    chk({tag, " drop_cnt"},    32'(drop_cnt),    32'(m_drop));
    chk({tag, " hi_water"},    32'(hi_water),    32'(m_hw));
`endif
  endtask

  // Drive one clock cycle of stimulus, advance the model, then check.
  task automatic cycle(input string tag, input logic iv, input logic [FLIT_W-1:0] d,
                       input logic ordy, input logic clr);
    bit mfull;
    bit mpush;
    bit mpop;
    in_valid     = iv;
    datain       = d;
    out_ready    = ordy;
    clr_overflow = clr;
    @(posedge clk);
    mfull = (sb_q.size() == DEPTH);
    mpush = iv && !mfull;
    mpop  = ordy && (sb_q.size() != 0);
    if (mpop) void'(sb_q.pop_front());
    if (mpush) sb_q.push_back(d);
    if (iv && mfull) begin
      m_ovf = 1;
      if (m_drop < 65535) m_drop++;
    end else if (clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (sb_q.size() > m_hw) m_hw = sb_q.size();
    #1;
    check_state(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ovf  = 0;
    m_drop = 0;
    m_hw   = 0;
  endtask

  // Pulse reset synchronously aligned to the negative edge, between tests.
  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0; datain = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Vector table: {in_valid, datain, out_ready, clr, count, overflow, dataout, payload}
    vtab[0] = '{1'b1, 20'hABCD1, 1'b0, 1'b0, 1, 1'b0, 20'hABCD1, 16'hABCD};
    vtab[1] = '{1'b1, 20'h12345, 1'b1, 1'b0, 1, 1'b0, 20'h12345, 16'h1234};
    vtab[2] = '{1'b0, 20'h00000, 1'b1, 1'b0, 0, 1'b0, 20'h00000, 16'h0000};
    vtab[3] = '{1'b1, 20'h0F0F3, 1'b1, 1'b0, 1, 1'b0, 20'h0F0F3, 16'h0F0F};
    vtab[4] = '{1'b0, 20'h55555, 1'b0, 1'b1, 1, 1'b0, 20'h0F0F3, 16'h0F0F};
    vtab[5] = '{1'b0, 20'h00000, 1'b1, 1'b0, 0, 1'b0, 20'h00000, 16'h0000};

    rst = 1'b0; in_valid = 1'b0; datain = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_state("por");
    @(negedge clk);
    rst = 1'b1;

    // Table: single push, push+pop, pop to empty, push+pop on empty, clr idle
    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("vec%0d", i), vtab[i].iv, vtab[i].d, vtab[i].ordy, vtab[i].clr);
      chk($sformatf("vec%0d tab_count", i), 32'(count), 32'(vtab[i].exp_count));
      chk($sformatf("vec%0d tab_ovf", i), 32'(overflow), 32'(vtab[i].exp_ovf));
      chk($sformatf("vec%0d tab_dout", i), 32'(dataout), 32'(vtab[i].exp_dout));
      chk($sformatf("vec%0d tab_payload", i), 32'(payload), 32'(vtab[i].exp_payload));
    end

    // Fill with 0..39; almost_full from 36, then full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle($sformatf("fill%0d", i), 1'b1, FLIT_W'(i), 1'b0, 1'b0);
    end
    chk("fill full", 32'(full), 32'd1);
    chk("fill count", 32'(count), 32'(DEPTH));

    // Overflow: write while full is dropped, head stays flit 0
    cycle("ovf", 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf head", 32'(dataout), 32'd0);
    cycle("ovf_clr", 1'b0, 20'h0, 1'b0, 1'b1);
    chk("ovf cleared", 32'(overflow), 32'd0);
    // Set wins over clear in the same cycle
    cycle("ovf_setwin", 1'b1, 20'hFFFFF, 1'b0, 1'b1);
    chk("ovf setwins", 32'(overflow), 32'd1);
    cycle("ovf_clr2", 1'b0, 20'h0, 1'b0, 1'b1);

    // Full with push+pop requested: pop only, count 39, in_ready back
    cycle("full_pp", 1'b1, 20'h77777, 1'b1, 1'b0);
    chk("full_pp count", 32'(count), 32'(DEPTH - 1));
    chk("full_pp in_ready", 32'(in_ready), 32'd1);
    cycle("full_pp_clr", 1'b0, 20'h0, 1'b0, 1'b1);

    // Drain remaining flits 1..39 in order
    for (int i = 1; i < DEPTH; i++) begin
      cycle($sformatf("drain%0d", i), 1'b0, 20'h0, 1'b1, 1'b0);
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain dataout", 32'(dataout), 32'd0);

    // Steady state at count 10 with push+pop each cycle; pointers wrap
    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("pre%0d", i), 1'b1, FLIT_W'(20'h10000 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      cycle($sformatf("steady%0d", i), 1'b1, FLIT_W'(20'h20000 + i), 1'b1, 1'b0);
    end
    chk("steady count", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("post%0d", i), 1'b0, 20'h0, 1'b1, 1'b0);
    end

    // Async reset mid-stream at count 25 with overflow set
    for (int i = 0; i < DEPTH; i++) begin
      cycle($sformatf("refill%0d", i), 1'b1, FLIT_W'(20'h30000 + i), 1'b0, 1'b0);
    end
    cycle("reovf", 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle($sformatf("part%0d", i), 1'b0, 20'h0, 1'b1, 1'b0);
    end
    chk("pre_arst count", 32'(count), 32'd25);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst count", 32'(count), 32'd0);
    chk("arst empty", 32'(empty), 32'd1);
    chk("arst overflow", 32'(overflow), 32'd0);
`ifdef NOC_INBUF_STATS_EN
    chk("arst hi_water", 32'(hi_water), 32'd0);
`endif
    check_state("arst");
    @(negedge clk);
    rst = 1'b1;
    cycle("after_arst", 1'b1, 20'h4AAA5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end

endmodule
